// File: rtl/pe_rst_pkg.sv
// Shared definitions for the TBI reset sequencer: state encodings,
// status-word bit positions and a small state classification helper.
package pe_rst_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_GLB   = 3'd2,
        ST_REL_TX    = 3'd3,
        ST_REL_RX    = 3'd4,
        ST_RUN       = 3'd5
    } seq_state_e;

    // Layout of the host-visible status word built from the sequencer outputs.
    localparam int STS_STATE_LSB = 0;
    localparam int STS_STATE_W   = 3;
    localparam int STS_BUSY_BIT  = 3;
    localparam int STS_ERR_BIT   = 4;
    localparam int STS_W         = 5;

    // States entered only after lock was qualified; losing lock here restarts the sequence.
    function automatic logic lock_watched(input seq_state_e st);
        case (st)
            ST_REL_GLB, ST_REL_TX, ST_REL_RX, ST_RUN: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count
// compare against a run-time value. Clear has priority over load, load over count.
module rst_seq_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, load, saturating increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, zero under asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/tbi_reset_sequencer.sv
// Sequences the global, TX and RX reset requests of the TBI clock/reset
// generator: hold, qualify PLL lock, then release glb -> tx -> rx, waiting for
// each domain's synchronised acknowledge. Any fault reasserts all resets at once.
module tbi_reset_sequencer
    import pe_rst_pkg::*;
#(
    parameter int HOLD_CYC   = 16,
    parameter int LOCK_CYC   = 64,
    parameter int ACK_TO_CYC = 1024,
    parameter int CNT_W      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    input  logic       div_mode_req,
    input  logic       pll_lock,
    input  logic       tx_rst_ack,
    input  logic       rx_rst_ack,
    output logic       glb_rst,
    output logic       tx_rst,
    output logic       rx_rst,
    output logic       div_mode,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_err,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(ACK_TO_CYC - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             glb_rst_q;
    logic             tx_rst_q;
    logic             rx_rst_q;
    logic             div_mode_q;
    logic             seq_busy_q;
    logic             seq_done_q;
    logic             seq_err_q;

    logic             main_clr_s;
    logic             main_inc_s;
    logic             main_tc_s;
    logic [CNT_W-1:0] main_tc_val_s;
    logic             to_clr_s;
    logic             to_inc_s;
    logic             to_tc_s;
    logic             err_set_s;
    logic             err_clr_s;

    // The shared counter times the hold in ASSERT and the lock qualification afterwards.
    assign main_tc_val_s = (state_q == ST_ASSERT) ? HOLD_TC : LOCK_TC;

    rst_seq_cnt #(.W(CNT_W)) u_main_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (main_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (main_inc_s),
        .tc_val_i   (main_tc_val_s),
        .tc_o       (main_tc_s)
    );

    rst_seq_cnt #(.W(CNT_W)) u_to_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (to_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (to_inc_s),
        .tc_val_i   (TO_TC),
        .tc_o       (to_tc_s)
    );

    // Next-state and counter control; soft reset beats lock loss beats normal flow.
    always_comb begin
        state_d    = state_q;
        main_clr_s = 1'b0;
        main_inc_s = 1'b0;
        to_clr_s   = 1'b0;
        to_inc_s   = 1'b0;
        err_set_s  = 1'b0;
        err_clr_s  = 1'b0;
        if (sw_rst_req) begin
            state_d    = ST_ASSERT;
            main_clr_s = 1'b1;
            to_clr_s   = 1'b1;
            err_clr_s  = 1'b1;
        end else if (!pll_lock && lock_watched(state_q)) begin
            state_d    = ST_ASSERT;
            main_clr_s = 1'b1;
            to_clr_s   = 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (main_tc_s) begin
                        state_d    = ST_WAIT_LOCK;
                        main_clr_s = 1'b1;
                        to_clr_s   = 1'b1;
                    end else begin
                        main_inc_s = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (pll_lock && main_tc_s) begin
                        state_d    = ST_REL_GLB;
                        main_clr_s = 1'b1;
                        to_clr_s   = 1'b1;
                    end else if (to_tc_s) begin
                        state_d    = ST_ASSERT;
                        main_clr_s = 1'b1;
                        to_clr_s   = 1'b1;
                        err_set_s  = 1'b1;
                    end else begin
                        to_inc_s   = 1'b1;
                        main_inc_s = pll_lock;
                        main_clr_s = !pll_lock;
                    end
                end
                ST_REL_GLB: begin
                    state_d  = ST_REL_TX;
                    to_clr_s = 1'b1;
                end
                ST_REL_TX: begin
                    if (!tx_rst_ack) begin
                        state_d  = ST_REL_RX;
                        to_clr_s = 1'b1;
                    end else if (to_tc_s) begin
                        state_d    = ST_ASSERT;
                        main_clr_s = 1'b1;
                        to_clr_s   = 1'b1;
                        err_set_s  = 1'b1;
                    end else begin
                        to_inc_s = 1'b1;
                    end
                end
                ST_REL_RX: begin
                    if (!rx_rst_ack) begin
                        state_d  = ST_RUN;
                        to_clr_s = 1'b1;
                    end else if (to_tc_s) begin
                        state_d    = ST_ASSERT;
                        main_clr_s = 1'b1;
                        to_clr_s   = 1'b1;
                        err_set_s  = 1'b1;
                    end else begin
                        to_inc_s = 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d    = ST_ASSERT;
                    main_clr_s = 1'b1;
                    to_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs; outputs are derived from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            glb_rst_q  <= 1'b1;
            tx_rst_q   <= 1'b1;
            rx_rst_q   <= 1'b1;
            div_mode_q <= 1'b0;
            seq_busy_q <= 1'b1;
            seq_done_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            glb_rst_q  <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK);
            tx_rst_q   <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_REL_GLB);
            rx_rst_q   <= (state_d != ST_REL_RX) && (state_d != ST_RUN);
            seq_busy_q <= (state_d != ST_RUN);
            seq_done_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
            if (state_q == ST_ASSERT) begin
                div_mode_q <= div_mode_req;
            end else begin
                div_mode_q <= div_mode_q;
            end
            if (err_clr_s) begin
                seq_err_q <= 1'b0;
            end else if (err_set_s) begin
                seq_err_q <= 1'b1;
            end else begin
                seq_err_q <= seq_err_q;
            end
        end
    end

    assign glb_rst   = glb_rst_q;
    assign tx_rst    = tx_rst_q;
    assign rx_rst    = rx_rst_q;
    assign div_mode  = div_mode_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign seq_err   = seq_err_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_tbi_reset_sequencer.sv
// Scoreboard bench for tbi_reset_sequencer: every state transition observed
// on seq_state is matched against the next expected entry (state, reset
// vector, busy, err, done, and dwell time of the state being left).
module tb_tbi_reset_sequencer;

    localparam logic [2:0] S_ASSERT = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_GLB    = 3'd2;
    localparam logic [2:0] S_TX     = 3'd3;
    localparam logic [2:0] S_RX     = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       div_mode_req = 1'b0;
    logic       pll_lock = 1'b1;
    logic       tx_rst_ack;
    logic       rx_rst_ack;
    logic       glb_rst, tx_rst, rx_rst, div_mode, seq_busy, seq_done, seq_err;
    logic [2:0] seq_state;

    logic       tx_stuck = 1'b0;
    logic       rx_stuck = 1'b0;
    logic [2:0] tx_pipe = 3'b111;
    logic [2:0] rx_pipe = 3'b111;

    typedef struct {
        logic [2:0] st;
        logic [2:0] rsts;
        logic       busy;
        logic       err;
        logic       done;
        int         dwell;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    tbi_reset_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw_rst_req),
        .div_mode_req (div_mode_req),
        .pll_lock     (pll_lock),
        .tx_rst_ack   (tx_rst_ack),
        .rx_rst_ack   (rx_rst_ack),
        .glb_rst      (glb_rst),
        .tx_rst       (tx_rst),
        .rx_rst       (rx_rst),
        .div_mode     (div_mode),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .seq_err      (seq_err),
        .seq_state    (seq_state)
    );

    always #5 clk = ~clk;

    // Domain synchronisers: acknowledge follows the reset request 3 cycles later.
    always @(negedge clk) begin
        tx_pipe <= {tx_pipe[1:0], tx_rst};
        rx_pipe <= {rx_pipe[1:0], rx_rst};
    end
    assign tx_rst_ack = tx_stuck | tx_pipe[2];
    assign rx_rst_ack = rx_stuck | rx_pipe[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [2:0] rsts, input logic busy,
                            input logic err, input logic done, input int dwell);
        exp_t e;
        e.st = st; e.rsts = rsts; e.busy = busy; e.err = err; e.done = done; e.dwell = dwell;
        sb.push_back(e);
    endtask

    // Expected pass from WAIT_LOCK to RUN with nominal lock and free-running acks.
    task automatic push_pass(input logic err, input int lock_dwell);
        push_exp(S_WAIT, 3'b111, 1'b1, err, 1'b0, 16);
        push_exp(S_GLB,  3'b011, 1'b1, err, 1'b0, lock_dwell);
        push_exp(S_TX,   3'b001, 1'b1, err, 1'b0, 1);
        push_exp(S_RX,   3'b000, 1'b1, err, 1'b0, -1);
        push_exp(S_RUN,  3'b000, 1'b0, err, 1'b1, -1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check_val({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rsts",  {glb_rst, tx_rst, rx_rst}, 3'b111);
        check_val("rst_div",   div_mode, 1'b0);
        check_val("rst_busy",  seq_busy, 1'b1);
        check_val("rst_done",  seq_done, 1'b0);
        check_val("rst_err",   seq_err, 1'b0);
        check_val("rst_state", seq_state, S_ASSERT);
        #1 rst_n = 1'b1;
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        @(negedge clk);
        #1 sw_rst_req = 1'b0;
    endtask

    // Monitor: pop and compare an expected entry on every observed state change.
    initial begin
        logic [2:0] prev_st;
        int         dwell;
        exp_t       e;
        prev_st = S_ASSERT;
        dwell = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_st = S_ASSERT;
                dwell = 0;
            end else begin
                if (seq_done) done_cnt++;
                if (seq_state != prev_st) begin
                    check_val("sb_pop", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_val("state", seq_state, e.st);
                        check_val("rsts", {glb_rst, tx_rst, rx_rst}, e.rsts);
                        check_val("busy", seq_busy, e.busy);
                        check_val("err", seq_err, e.err);
                        check_val("done", seq_done, e.done);
                        if (e.dwell >= 0) check_val("dwell", dwell, e.dwell);
                    end
                    prev_st = seq_state;
                    dwell = 1;
                end else begin
                    dwell++;
                end
            end
        end
    end

    initial begin
        // Power-up sequence with stable lock.
        push_pass(1'b0, 64);
        apply_reset();
        wait_drain("powerup", 300);
        repeat (3) @(negedge clk);
        #1;
        check_val("pu_done_cnt", done_cnt, 1);
        check_val("pu_busy", seq_busy, 1'b0);
        check_val("pu_state", seq_state, S_RUN);

        // One-cycle lock glitch at lock count 40 delays release by 41 cycles.
        push_pass(1'b0, 105);
        apply_reset();
        @(negedge clk);
        repeat (56) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_drain("glitch", 300);
        check_val("gl_err", seq_err, 1'b0);
        check_val("gl_done_cnt", done_cnt, 2);

        // TX acknowledge stuck: timeout after 1024 cycles, err set, sequence restarts.
        tx_stuck = 1'b1;
        push_exp(S_WAIT,   3'b111, 1'b1, 1'b0, 1'b0, 16);
        push_exp(S_GLB,    3'b011, 1'b1, 1'b0, 1'b0, 64);
        push_exp(S_TX,     3'b001, 1'b1, 1'b0, 1'b0, 1);
        push_exp(S_ASSERT, 3'b111, 1'b1, 1'b1, 1'b0, 1024);
        apply_reset();
        wait_drain("timeout", 1300);
        tx_stuck = 1'b0;
        push_pass(1'b1, 64);
        wait_drain("retry", 300);
        repeat (3) @(negedge clk);
        #1;
        check_val("to_err_sticky", seq_err, 1'b1);
        check_val("to_done_cnt", done_cnt, 3);

        // Soft reset in RUN with divide mode requested during ASSERT.
        div_mode_req = 1'b1;
        push_exp(S_ASSERT, 3'b111, 1'b1, 1'b0, 1'b0, -1);
        push_pass(1'b0, 64);
        sw_pulse();
        wait_drain("swrst", 300);
        check_val("sw_div", div_mode, 1'b1);
        div_mode_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_val("sw_div_hold", div_mode, 1'b1);
        check_val("sw_done_cnt", done_cnt, 4);

        // Lock loss in RUN: reassert without err, resume on relock.
        push_exp(S_ASSERT, 3'b111, 1'b1, 1'b0, 1'b0, -1);
        push_exp(S_WAIT,   3'b111, 1'b1, 1'b0, 1'b0, 16);
        pll_lock = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check_val("ll_drain", sb.size(), 0);
        check_val("ll_done_cnt", done_cnt, 4);
        check_val("ll_err", seq_err, 1'b0);
        push_exp(S_GLB, 3'b011, 1'b1, 1'b0, 1'b0, 77);
        push_exp(S_TX,  3'b001, 1'b1, 1'b0, 1'b0, 1);
        push_exp(S_RX,  3'b000, 1'b1, 1'b0, 1'b0, -1);
        push_exp(S_RUN, 3'b000, 1'b0, 1'b0, 1'b1, -1);
        pll_lock = 1'b1;
        wait_drain("relock", 300);
        check_val("rl_done_cnt", done_cnt, 5);

        // Asynchronous reset pulse while parked in REL_RX.
        rx_stuck = 1'b1;
        push_exp(S_ASSERT, 3'b111, 1'b1, 1'b0, 1'b0, -1);
        push_exp(S_WAIT,   3'b111, 1'b1, 1'b0, 1'b0, 16);
        push_exp(S_GLB,    3'b011, 1'b1, 1'b0, 1'b0, 64);
        push_exp(S_TX,     3'b001, 1'b1, 1'b0, 1'b0, 1);
        push_exp(S_RX,     3'b000, 1'b1, 1'b0, 1'b0, -1);
        sw_pulse();
        wait_drain("to_rx", 300);
        repeat (5) @(negedge clk);
        check_val("pre_async_state", seq_state, S_RX);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rsts",  {glb_rst, tx_rst, rx_rst}, 3'b111);
        check_val("async_state", seq_state, S_ASSERT);
        check_val("async_busy",  seq_busy, 1'b1);
        check_val("async_div",   div_mode, 1'b0);
        check_val("async_err",   seq_err, 1'b0);
        #1 rst_n = 1'b1;
        rx_stuck = 1'b0;
        push_pass(1'b0, 64);
        wait_drain("async_restart", 300);
        repeat (3) @(negedge clk);
        #1;
        check_val("final_done_cnt", done_cnt, 6);
        check_val("final_state", seq_state, S_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tbi_reset_sequencer.md
Name: tbi_reset_sequencer

Overview:
- Single-clock controller that sequences the reset request inputs of the TBI clock/reset generator.
- Drives the generator's global, transmit and receive reset requests, and the clock-divide mode select.
- Releases the TX and RX domains in a fixed order, after PLL lock is stable and each domain's synchronised reset has been acknowledged.
- Sits between the host register block (soft reset, mode) and the clock/reset generator.

Parameters:
- HOLD_CYC, 16, cycles all resets are held asserted in ASSERT (minimum 2).
- LOCK_CYC, 64, consecutive cycles pll_lock must be high before release.
- ACK_TO_CYC, 1024, maximum cycles to wait for the lock or for a domain acknowledge before retrying.
- CNT_W, 11, width of the shared cycle counter; must satisfy 2^CNT_W > max(HOLD_CYC, LOCK_CYC, ACK_TO_CYC).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_rst_req  in  1  soft reset request pulse from the host, level or pulse, sampled each cycle
- div_mode_req  in  1  requested clock-divide (TBI 10-bit) mode
- pll_lock  in  1  PLL lock, already synchronised to clk
- tx_rst_ack  in  1  TX-domain synchronised reset fed back, 1 = still in reset (synchronised to clk)
- rx_rst_ack  in  1  RX-domain synchronised reset fed back, 1 = still in reset (synchronised to clk)
- glb_rst  out  1  global reset request to the generator
- tx_rst  out  1  TX reset request
- rx_rst  out  1  RX reset request
- div_mode  out  1  registered mode select to the generator
- seq_busy  out  1  high whenever state is not RUN
- seq_done  out  1  one-cycle pulse on entry to RUN
- seq_err  out  1  sticky timeout flag, cleared by sw_rst_req or rst_n
- seq_state  out  3  current state encoding, for status read

Behaviour:
- During rst_n low: state is ASSERT, counter = 0, and the outputs are:
  - glb_rst = tx_rst = rx_rst = 1
  - div_mode = 0
  - seq_busy = 1
  - seq_done = 0, seq_err = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States and encodings: ASSERT=0, WAIT_LOCK=1, REL_GLB=2, REL_TX=3, REL_RX=4, RUN=5. Encodings 6 and 7 go to ASSERT.
- ASSERT:
  - All three resets are 1.
  - div_mode is loaded from div_mode_req on every cycle in this state only.
  - The counter increments; when counter == HOLD_CYC-1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - The lock counter increments while pll_lock = 1 and clears to 0 when pll_lock = 0.
  - When the lock counter reaches LOCK_CYC-1 with pll_lock still 1, go to REL_GLB.
  - A separate timeout counter counts in this state; at ACK_TO_CYC-1, set seq_err and go to ASSERT.
- REL_GLB: glb_rst = 0 for one cycle, then go to REL_TX.
- REL_TX:
  - tx_rst = 0; wait for tx_rst_ack = 0, then go to REL_RX.
  - Timeout at ACK_TO_CYC-1 sets seq_err and goes to ASSERT.
- REL_RX:
  - rx_rst = 0; wait for rx_rst_ack = 0, then go to RUN.
  - The timeout works as in REL_TX.
- RUN:
  - All resets are 0 and seq_busy = 0.
  - seq_done pulses for exactly one cycle on entry.
- Priority, highest first:
  1. rst_n
  2. sw_rst_req — from any state, go to ASSERT next cycle, clear counters, clear seq_err, and reassert all resets next cycle.
  3. pll_lock falling in REL_GLB, REL_TX, REL_RX or RUN — go to ASSERT; seq_err is not set.
  4. Normal transitions.
- sw_rst_req held high keeps the block in ASSERT with the counter held at 0; HOLD_CYC counts from the first cycle it is low.
- Simultaneous sw_rst_req and timeout in the same cycle: sw_rst_req wins and seq_err stays 0.
- A change of div_mode_req outside ASSERT is ignored until the next sequence.
- Reset outputs are only ever released in the order glb, then tx, then rx. Reassertion is always simultaneous.
- Counters saturate rather than wrap.

Decomposition:
- Shared package (pe_rst_pkg): state encodings and the status bit positions for seq_state, seq_busy and seq_err.
- One sub-module, rst_seq_cnt: a loadable saturating counter with clear, a terminal-count compare output and a width parameter.
  - Instantiated twice: once as the shared hold/lock counter, once as the timeout counter.

Test Plan:
- Power-up: rst_n released, pll_lock high from the start, acks fall 3 cycles after each release.
  - Required: glb_rst falls at cycle 16+64+1, then tx_rst, then rx_rst; seq_done pulses once; seq_busy = 0; seq_state = 5.
- Lock glitch: pll_lock drops for 1 cycle at lock count 40.
  - Required: the lock count restarts and the release is delayed by 41 cycles; seq_err = 0.
- Ack timeout: tx_rst_ack stuck at 1.
  - Required: after 1024 cycles in REL_TX, seq_err = 1, all resets reassert and the sequence restarts.
  - Then release tx_rst_ack; the next pass completes and seq_err stays 1 until sw_rst_req.
- Soft reset in RUN: a 1-cycle sw_rst_req.
  - Required: the next cycle has all resets = 1, seq_state = 0 and seq_err cleared; the full sequence replays.
  - With div_mode_req = 1 during ASSERT, div_mode = 1 afterwards.
- Lock loss in RUN: pll_lock falls.
  - Required: the next cycle is ASSERT with all resets = 1 and seq_err = 0; on relock the sequence resumes with no extra seq_done.
- Async reset mid-REL_RX: rst_n pulsed low for a partial cycle.
  - Required: outputs go to reset values immediately, without waiting for a clk edge, and the sequence restarts from ASSERT.
